// File: rtl/readout_stepper_pkg.sv
// Shared types and helpers for the post-run readout stepper.
// The FSM states and the index-width rule are used by the stepper and its bench.
package readout_stepper_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHOW  = 2'd2
  } state_e;

  // Index width for n addressable words; never narrower than one bit.
  function automatic int calc_aw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/readout_stepper_button_debounce.sv
// Push-button conditioning: 2-flop synchroniser, stability counter and a
// one-cycle pulse on every accepted 0->1 transition.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic button_i,
  output logic step_o
);

  localparam int CW = (DEBOUNCE_CYCLES <= 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          step_q, step_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      step_q  <= 1'b0;
    end else begin
      sync1_q <= button_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
    end
  end

  // The count only survives while the synchronised level keeps disagreeing
  // with the accepted one; any agreeing cycle starts it over.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    step_d  = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        step_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign step_o = step_q;

endmodule

// File: rtl/readout_stepper.sv
// Post-run result viewer: once the core halts, each debounced button press
// steps an index through a read port and shows the selected word.
module readout_stepper
  import readout_stepper_pkg::*;
#(
  parameter int WIDTH           = 32,
  parameter int NUM_REGS        = 32,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int RD_LATENCY      = 1,
  parameter int WRAP            = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          button,
  input  logic                          dir,
  input  logic                          halted,
  output logic [calc_aw(NUM_REGS)-1:0]  rd_addr,
  input  logic [WIDTH-1:0]              rd_data,
  output logic [WIDTH-1:0]              out,
  output logic [calc_aw(NUM_REGS)-1:0]  idx,
  output logic                          valid
);

  localparam int AW = calc_aw(NUM_REGS);
  localparam int LW = (RD_LATENCY <= 1) ? 1 : $clog2(RD_LATENCY);
  localparam logic [AW-1:0] IDX_LAST = AW'(NUM_REGS - 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(RD_LATENCY - 1);

  logic step;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .button_i (button),
    .step_o   (step)
  );

  state_e           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             valid_q, valid_d;
  logic             pend_q, pend_d;
  logic             pend_dir_q, pend_dir_d;
  logic [LW-1:0]    lat_q, lat_d;
  logic [AW-1:0]    nxt_idx;

  // Explicit end checks keep a non-power-of-two range from leaking past NUM_REGS-1.
  function automatic logic [AW-1:0] next_index(input logic [AW-1:0] cur, input logic down);
    if (!down) begin
      if (cur == IDX_LAST) return (WRAP != 0) ? '0 : cur;
      return cur + AW'(1);
    end
    if (cur == '0) return (WRAP != 0) ? IDX_LAST : cur;
    return cur - AW'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      addr_q     <= '0;
      out_q      <= '0;
      valid_q    <= 1'b0;
      pend_q     <= 1'b0;
      pend_dir_q <= 1'b0;
      lat_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      out_q      <= out_d;
      valid_q    <= valid_d;
      pend_q     <= pend_d;
      pend_dir_q <= pend_dir_d;
      lat_q      <= lat_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    out_d      = out_q;
    valid_d    = valid_q;
    pend_d     = pend_q;
    pend_dir_d = pend_dir_q;
    lat_d      = lat_q;
    nxt_idx    = next_index(idx_q, pend_q ? pend_dir_q : dir);

    // Losing halted beats everything, including a step in the same cycle.
    if (!halted) begin
      state_d = IDLE;
      valid_d = 1'b0;
      pend_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          idx_d   = '0;
          addr_d  = '0;
          lat_d   = '0;
          valid_d = 1'b0;
          state_d = FETCH;
        end
        FETCH: begin
          if (step && !pend_q) begin
            pend_d     = 1'b1;
            pend_dir_d = dir;
          end
          if (lat_q == LAT_LAST) begin
            out_d   = rd_data;
            valid_d = 1'b1;
            lat_d   = '0;
            state_d = SHOW;
          end else begin
            lat_d = lat_q + LW'(1);
          end
        end
        SHOW: begin
          // A saturated step still refetches so valid visibly re-asserts.
          if (step || pend_q) begin
            idx_d   = nxt_idx;
            addr_d  = nxt_idx;
            valid_d = 1'b0;
            pend_d  = 1'b0;
            lat_d   = '0;
            state_d = FETCH;
          end
        end
        default: begin
          state_d = IDLE;
          valid_d = 1'b0;
          pend_d  = 1'b0;
        end
      endcase
    end
  end

  assign rd_addr = addr_q;
  assign out     = out_q;
  assign idx     = idx_q;
  assign valid   = valid_q;

endmodule
